router_fifo: RTL and testbench



---
 rtl/router_fifo.sv | 122 ++++++++++++
 tb/tb_router_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: stores bytes tagged with a header (lfd) flag and tracks remaining packet length on the read side.
// Optional sticky overflow/underflow flags are enabled by defining ROUTER_FIFO_ERR_EN.
module router_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   input  logic             read_enb,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
`ifdef ROUTER_FIFO_ERR_EN
   output logic             ovf_err,
   output logic             udf_err,
`endif
   output logic             pkt_active
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = 7;

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic [WIDTH:0]   mem_q [DEPTH];
   logic [WIDTH:0]   rd_entry_c;
   logic             wr_acc_c;
   logic             rd_acc_c;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty      = (wptr_q == rptr_q);
   assign full       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign data_out   = data_out_q;
   assign pkt_active = (pkt_cnt_q != CW'(0));

   assign wr_acc_c   = write_enb && !full && !soft_reset && !reset;
   assign rd_acc_c   = read_enb && !empty && !soft_reset;
   assign rd_entry_c = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      data_out_d = data_out_q;
      pkt_cnt_d  = pkt_cnt_q;
      if (soft_reset) begin
         wptr_d     = '0;
         rptr_d     = '0;
         data_out_d = '0;
         pkt_cnt_d  = '0;
      end else begin
         if (wr_acc_c) begin
            wptr_d = wptr_q + PW'(1);
         end
         if (rd_acc_c) begin
            rptr_d     = rptr_q + PW'(1);
            data_out_d = rd_entry_c[WIDTH-1:0];
            // Header loads payload length plus one parity byte.
            if (rd_entry_c[WIDTH]) begin
               pkt_cnt_d = CW'(rd_entry_c[WIDTH-1:2]) + CW'(1);
            end else if (pkt_cnt_q != CW'(0)) begin
               pkt_cnt_d = pkt_cnt_q - CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         data_out_q <= '0;
         pkt_cnt_q  <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         data_out_q <= data_out_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   // Storage has no reset; contents are only meaningful between the pointers.
   always_ff @(posedge clock) begin
      if (wr_acc_c) begin
         mem_q[wptr_q[AW-1:0]] <= {lfd_state, data_in};
      end
   end

`ifdef ROUTER_FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   assign ovf_err = ovf_q;
   assign udf_err = udf_q;

   always_comb begin
      ovf_d = ovf_q || (write_enb && full);
      udf_d = udf_q || (read_enb && empty);
      if (soft_reset) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Bench for router_fifo: directed packet scenarios followed by random traffic, checked against a queue-based model.
module tb_router_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             soft_reset = 1'b0;
   logic             write_enb = 1'b0;
   logic             lfd_state = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             read_enb = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;
   logic             pkt_active;
`ifdef ROUTER_FIFO_ERR_EN
   logic             ovf_err;
   logic             udf_err;
`endif

   always #5 clock = ~clock;

   router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .read_enb   (read_enb),
      .data_out   (data_out),
      .full       (full),
      .empty      (empty),
`ifdef ROUTER_FIFO_ERR_EN
      .ovf_err    (ovf_err),
      .udf_err    (udf_err),
`endif
      .pkt_active (pkt_active)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [8:0] m_q [$];
   logic [7:0] m_dout = '0;
   int         m_cnt  = 0;
   bit         m_ovf  = 1'b0;
   bit         m_udf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, advance model on the edge, compare just after it.
   task automatic step(input bit we, input bit lfd, input logic [7:0] din, input bit re, input bit sr);
      bit         wacc, racc;
      logic [8:0] e;
      write_enb  = we;
      lfd_state  = lfd;
      data_in    = din;
      read_enb   = re;
      soft_reset = sr;
      @(posedge clock);
      if (reset || sr) begin
         m_q.delete();
         m_dout = '0;
         m_cnt  = 0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         wacc = we && (m_q.size() < DEPTH);
         racc = re && (m_q.size() > 0);
         if (we && m_q.size() == DEPTH) m_ovf = 1'b1;
         if (re && m_q.size() == 0) m_udf = 1'b1;
         if (racc) begin
            e      = m_q.pop_front();
            m_dout = e[7:0];
            if (e[8]) m_cnt = int'(e[7:2]) + 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
         end
         if (wacc) m_q.push_back({lfd, din});
      end
      #1;
      check("data_out", 32'(data_out), 32'(m_dout));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("pkt_active", 32'(pkt_active), 32'(m_cnt != 0));
`ifdef ROUTER_FIFO_ERR_EN
      check("ovf_err", 32'(ovf_err), 32'(m_ovf));
      check("udf_err", 32'(udf_err), 32'(m_udf));
`endif
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      soft_reset = 1'b0;
      lfd_state  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic wr(input bit lfd, input logic [7:0] din);
      step(1'b1, lfd, din, 1'b0, 1'b0);
   endtask

   task automatic rd();
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      do_reset();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_dout", 32'(data_out), 32'h0);

      // One packet: header length 3, three payload bytes, parity
      wr(1'b1, 8'h0D);
      wr(1'b0, 8'h11);
      wr(1'b0, 8'h22);
      wr(1'b0, 8'h33);
      wr(1'b0, 8'h3C);
      rd();
      check("pkt_hdr", 32'(data_out), 32'h0D);
      check("pkt_act_hdr", 32'(pkt_active), 32'd1);
      rd(); rd(); rd(); rd();
      check("pkt_par", 32'(data_out), 32'h3C);
      check("pkt_act_end", 32'(pkt_active), 32'd0);

      // Fill to full, drop one write, drain in order
      for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
      check("fill_full", 32'(full), 32'd1);
      wr(1'b0, 8'hFF);
`ifdef ROUTER_FIFO_ERR_EN
      check("ovf_set", 32'(ovf_err), 32'd1);
`endif
      for (int i = 0; i < 16; i++) begin
         rd();
         check("drain_data", 32'(data_out), 32'(i));
      end
      check("drain_empty", 32'(empty), 32'd1);
`ifdef ROUTER_FIFO_ERR_EN
      check("ovf_sticky", 32'(ovf_err), 32'd1);
`endif

      // Read while empty holds data_out, then write/read round trip
      rd();
      check("udf_hold", 32'(data_out), 32'h0F);
`ifdef ROUTER_FIFO_ERR_EN
      check("udf_set", 32'(udf_err), 32'd1);
`endif
      wr(1'b0, 8'h5A);
      rd();
      check("rt_data", 32'(data_out), 32'h5A);
      do_reset();
`ifdef ROUTER_FIFO_ERR_EN
      check("ovf_rst", 32'(ovf_err), 32'd0);
`endif

      // Simultaneous read and write while full
      for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h20 + 8'(i)));
      step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
      check("rw_full_data", 32'(data_out), 32'h20);
      check("rw_full_clr", 32'(full), 32'd0);
      for (int i = 0; i < 15; i++) rd();
      check("rw_full_last", 32'(data_out), 32'h2F);
      check("rw_full_empty", 32'(empty), 32'd1);

      // Soft reset mid-packet with a concurrent write
      wr(1'b1, 8'h14);
      wr(1'b0, 8'hA1);
      wr(1'b0, 8'hA2);
      wr(1'b0, 8'hA3);
      wr(1'b0, 8'hA4);
      rd();
      check("sr_act", 32'(pkt_active), 32'd1);
      step(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
      check("sr_empty", 32'(empty), 32'd1);
      check("sr_dout", 32'(data_out), 32'h0);
      check("sr_act_clr", 32'(pkt_active), 32'd0);
`ifdef ROUTER_FIFO_ERR_EN
      check("udf_sr_clr", 32'(udf_err), 32'd0);
`endif
      rd();
      check("sr_no_write", 32'(data_out), 32'h0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 20, 8'($urandom),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 199) < 2);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
